// File: rtl/alarm_ctrl_fsm.sv
// Alarm sequencing FSM: arm/disarm, ringing, snooze, auto-timeout and 1 Hz buzzer pattern.
// Latency: an input event on cycle N is visible on the registered outputs at cycle N+1.
// Backpressure: none; button pulses and ticks are consumed in the cycle they arrive.
// Optional snooze support is compiled in with `define ALARM_CTRL_SNOOZE_EN.
module alarm_ctrl_fsm #(
    parameter int SNOOZE_MIN     = 5,
    parameter int RING_TIMEOUT_S = 60,
    parameter int MAX_SNOOZES    = 3,
    parameter int CNT_W          = 10
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    input  logic             clk_1hz_en,
    input  logic             arm_btn,
    input  logic             off_btn,
    input  logic             snooze_btn,
    input  logic             alarm_match,
    output logic             alarm_enable,
    output logic             ringing,
    output logic             buzzer,
    output logic             snooze_active,
    output logic [CNT_W-1:0] snooze_remaining,
    output logic [2:0]       state_dbg
);

    localparam logic [2:0] S_DISARMED   = 3'd0;
    localparam logic [2:0] S_ARMED      = 3'd1;
    localparam logic [2:0] S_RINGING    = 3'd2;
    localparam logic [2:0] S_SNOOZE     = 3'd3;
    localparam logic [2:0] S_WAIT_CLEAR = 3'd4;

    localparam logic [CNT_W-1:0] RING_LAST = CNT_W'(RING_TIMEOUT_S - 1);

    logic [2:0]       r_state;
    logic             r_match_d;
    logic [CNT_W-1:0] r_ring_cnt;
    logic             r_buzzer;
    logic             r_alarm_enable;
    logic             r_ringing;

    logic [2:0]       w_state_nxt;
    logic [CNT_W-1:0] w_ring_nxt;
    logic             w_buzz_nxt;
    logic             w_match_rise;
    logic             w_timeout;
    logic [2:0]       w_off_dest;

`ifdef ALARM_CTRL_SNOOZE_EN
    localparam int               SC_RAW      = $clog2(MAX_SNOOZES + 1);
    localparam int               SC_W        = (SC_RAW < 1) ? 1 : SC_RAW;
    localparam logic [SC_W-1:0]  MAX_SC      = SC_W'(MAX_SNOOZES);
    localparam logic [CNT_W-1:0] SNOOZE_LOAD = CNT_W'(SNOOZE_MIN * 60);

    logic [SC_W-1:0]  r_snooze_cnt;
    logic [CNT_W-1:0] r_snooze_rem;
    logic             r_snooze_active;
    logic [SC_W-1:0]  w_scnt_nxt;
    logic [CNT_W-1:0] w_rem_nxt;
    logic             w_can_snooze;

    assign w_can_snooze = (r_snooze_cnt < MAX_SC);
`else
    // Snooze inputs/parameters have no function in this build.
    logic w_unused;
    assign w_unused = snooze_btn ^ (SNOOZE_MIN > 0) ^ (MAX_SNOOZES > 0);
`endif

    // Only a fresh minute match rings; arming mid-match sees no edge.
    assign w_match_rise = alarm_match & ~r_match_d;
    assign w_timeout    = clk_1hz_en && (r_ring_cnt == RING_LAST);
    // Stopping inside the matching minute parks in WAIT_CLEAR to block a re-trigger.
    assign w_off_dest   = alarm_match ? S_WAIT_CLEAR : S_ARMED;

    // Next-state and counter update; button checks precede timeouts.
    always_comb begin
        w_state_nxt = r_state;
        w_ring_nxt  = r_ring_cnt;
        w_buzz_nxt  = r_buzzer;
`ifdef ALARM_CTRL_SNOOZE_EN
        w_scnt_nxt  = r_snooze_cnt;
        w_rem_nxt   = r_snooze_rem;
`endif
        case (r_state)
            S_DISARMED: begin
                if (arm_btn) w_state_nxt = S_ARMED;
            end
            S_ARMED: begin
                if (arm_btn) begin
                    w_state_nxt = S_DISARMED;
                end else if (w_match_rise) begin
                    w_state_nxt = S_RINGING;
                    w_ring_nxt  = '0;
                    w_buzz_nxt  = 1'b1;
                end
            end
            S_RINGING: begin
                if (off_btn) begin
                    w_state_nxt = w_off_dest;
                end
`ifdef ALARM_CTRL_SNOOZE_EN
                else if ((snooze_btn || w_timeout) && w_can_snooze) begin
                    w_state_nxt = S_SNOOZE;
                    w_rem_nxt   = SNOOZE_LOAD;
                    w_scnt_nxt  = r_snooze_cnt + SC_W'(1);
                end
`endif
                else if (w_timeout) begin
                    w_state_nxt = w_off_dest;
                end else if (clk_1hz_en) begin
                    if (r_ring_cnt != {CNT_W{1'b1}}) w_ring_nxt = r_ring_cnt + CNT_W'(1);
                    w_buzz_nxt = ~r_buzzer;
                end
            end
`ifdef ALARM_CTRL_SNOOZE_EN
            S_SNOOZE: begin
                if (off_btn) begin
                    w_state_nxt = w_off_dest;
                end else if (arm_btn) begin
                    w_state_nxt = S_DISARMED;
                end else if (clk_1hz_en) begin
                    if (r_snooze_rem <= CNT_W'(1)) begin
                        w_state_nxt = S_RINGING;
                        w_ring_nxt  = '0;
                        w_buzz_nxt  = 1'b1;
                        w_rem_nxt   = '0;
                    end else begin
                        w_rem_nxt = r_snooze_rem - CNT_W'(1);
                    end
                end
            end
`endif
            S_WAIT_CLEAR: begin
                if (arm_btn) begin
                    w_state_nxt = S_DISARMED;
                end else if (!alarm_match) begin
                    w_state_nxt = S_ARMED;
                end
            end
            default: w_state_nxt = S_DISARMED;
        endcase

        // Buzzer and ring counter only live inside RINGING.
        if (w_state_nxt != S_RINGING) begin
            w_buzz_nxt = 1'b0;
            w_ring_nxt = '0;
        end
`ifdef ALARM_CTRL_SNOOZE_EN
        if (w_state_nxt != S_SNOOZE) w_rem_nxt = '0;
        if ((w_state_nxt == S_ARMED) || (w_state_nxt == S_DISARMED) ||
            (w_state_nxt == S_WAIT_CLEAR)) begin
            w_scnt_nxt = '0;
        end
`endif
    end

    // State, counters and registered outputs; reset forces DISARMED with all outputs low.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_DISARMED;
            r_match_d      <= 1'b0;
            r_ring_cnt     <= '0;
            r_buzzer       <= 1'b0;
            r_alarm_enable <= 1'b0;
            r_ringing      <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_match_d      <= alarm_match;
            r_ring_cnt     <= w_ring_nxt;
            r_buzzer       <= w_buzz_nxt;
            r_alarm_enable <= (w_state_nxt != S_DISARMED);
            r_ringing      <= (w_state_nxt == S_RINGING);
        end
    end

`ifdef ALARM_CTRL_SNOOZE_EN
    // Snooze bookkeeping registers.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_snooze_cnt    <= '0;
            r_snooze_rem    <= '0;
            r_snooze_active <= 1'b0;
        end else begin
            r_snooze_cnt    <= w_scnt_nxt;
            r_snooze_rem    <= w_rem_nxt;
            r_snooze_active <= (w_state_nxt == S_SNOOZE);
        end
    end

    assign snooze_active    = r_snooze_active;
    assign snooze_remaining = r_snooze_rem;
`else
    assign snooze_active    = 1'b0;
    assign snooze_remaining = '0;
`endif

    assign alarm_enable = r_alarm_enable;
    assign ringing      = r_ringing;
    assign buzzer       = r_buzzer;
    assign state_dbg    = r_state;

endmodule

// File: tb/tb_alarm_ctrl_fsm.sv
// Bench for alarm_ctrl_fsm with a short snooze/timeout configuration.
// Each step drives inputs on the falling edge, queues the expected outputs,
// and compares them 1 ns after the following rising edge.
module tb_alarm_ctrl_fsm;

    localparam int CNT_W = 10;

    logic             sys_clk;
    logic             rst_n;
    logic             clk_1hz_en;
    logic             arm_btn;
    logic             off_btn;
    logic             snooze_btn;
    logic             alarm_match;
    logic             alarm_enable;
    logic             ringing;
    logic             buzzer;
    logic             snooze_active;
    logic [CNT_W-1:0] snooze_remaining;
    logic [2:0]       state_dbg;

    alarm_ctrl_fsm #(
        .SNOOZE_MIN     (1),
        .RING_TIMEOUT_S (5),
        .MAX_SNOOZES    (2),
        .CNT_W          (CNT_W)
    ) dut (
        .sys_clk          (sys_clk),
        .rst_n            (rst_n),
        .clk_1hz_en       (clk_1hz_en),
        .arm_btn          (arm_btn),
        .off_btn          (off_btn),
        .snooze_btn       (snooze_btn),
        .alarm_match      (alarm_match),
        .alarm_enable     (alarm_enable),
        .ringing          (ringing),
        .buzzer           (buzzer),
        .snooze_active    (snooze_active),
        .snooze_remaining (snooze_remaining),
        .state_dbg        (state_dbg)
    );

    typedef struct packed {
        logic             en;
        logic             ring;
        logic             buzz;
        logic             sact;
        logic [CNT_W-1:0] rem;
        logic [2:0]       st;
    } exp_t;

    typedef struct {
        int   arm;
        int   off;
        int   snz;
        int   tick;
        int   match;
        exp_t e;
    } vec_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    vec_t tbl[20];

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic exp_t E(input int en, input int ring, input int buzz,
                               input int sact, input int rem, input int st);
        exp_t r;
        r.en   = (en != 0);
        r.ring = (ring != 0);
        r.buzz = (buzz != 0);
        r.sact = (sact != 0);
        r.rem  = CNT_W'(rem);
        r.st   = 3'(st);
        return r;
    endfunction

    function automatic vec_t V(input int a, input int o, input int s, input int t,
                               input int m, input exp_t e);
        vec_t r;
        r.arm = a; r.off = o; r.snz = s; r.tick = t; r.match = m; r.e = e;
        return r;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic compare_front(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty got 0 expected 1 entry", tag);
            return;
        end
        e = exp_q.pop_front();
        chk({tag, ".alarm_enable"},     16'(alarm_enable),     16'(e.en));
        chk({tag, ".ringing"},          16'(ringing),          16'(e.ring));
        chk({tag, ".buzzer"},           16'(buzzer),           16'(e.buzz));
        chk({tag, ".snooze_active"},    16'(snooze_active),    16'(e.sact));
        chk({tag, ".snooze_remaining"}, 16'(snooze_remaining), 16'(e.rem));
        chk({tag, ".state_dbg"},        16'(state_dbg),        16'(e.st));
    endtask

    task automatic step(input int a, input int o, input int s, input int t, input int m,
                        input exp_t e, input string tag);
        @(negedge sys_clk);
        arm_btn     = (a != 0);
        off_btn     = (o != 0);
        snooze_btn  = (s != 0);
        clk_1hz_en  = (t != 0);
        alarm_match = (m != 0);
        exp_q.push_back(e);
        @(posedge sys_clk);
        #1;
        compare_front(tag);
    endtask

    // Four ticks after entering RINGING: buzzer toggles 0,1,0,1.
    task automatic four_ticks(input int m, input string tag);
        for (int t = 1; t <= 4; t++) begin
            step(0, 0, 0, 1, m, E(1, 1, (t % 2 == 0) ? 1 : 0, 0, 0, 2), tag);
        end
    endtask

    initial begin
        // arm off snz tick match | en ring buzz sact rem st
        tbl[0]  = V(1, 0, 0, 0, 0, E(1, 0, 0, 0, 0, 1));
        tbl[1]  = V(0, 0, 0, 0, 0, E(1, 0, 0, 0, 0, 1));
        tbl[2]  = V(0, 0, 0, 0, 1, E(1, 1, 1, 0, 0, 2));
        tbl[3]  = V(0, 0, 0, 1, 1, E(1, 1, 0, 0, 0, 2));
        tbl[4]  = V(0, 0, 0, 1, 1, E(1, 1, 1, 0, 0, 2));
        tbl[5]  = V(0, 0, 0, 1, 1, E(1, 1, 0, 0, 0, 2));
        tbl[6]  = V(0, 0, 0, 1, 1, E(1, 1, 1, 0, 0, 2));
        tbl[7]  = V(0, 0, 0, 0, 1, E(1, 1, 1, 0, 0, 2));
        tbl[8]  = V(0, 1, 1, 0, 1, E(1, 0, 0, 0, 0, 4));
        tbl[9]  = V(0, 0, 0, 0, 1, E(1, 0, 0, 0, 0, 4));
        tbl[10] = V(0, 0, 0, 0, 0, E(1, 0, 0, 0, 0, 1));
        tbl[11] = V(1, 0, 0, 0, 0, E(0, 0, 0, 0, 0, 0));
        tbl[12] = V(0, 0, 0, 0, 1, E(0, 0, 0, 0, 0, 0));
        tbl[13] = V(1, 0, 0, 0, 1, E(1, 0, 0, 0, 0, 1));
        tbl[14] = V(0, 0, 0, 1, 1, E(1, 0, 0, 0, 0, 1));
        tbl[15] = V(0, 0, 0, 0, 0, E(1, 0, 0, 0, 0, 1));
        tbl[16] = V(0, 0, 0, 0, 1, E(1, 1, 1, 0, 0, 2));
        tbl[17] = V(0, 1, 1, 0, 0, E(1, 0, 0, 0, 0, 1));
        tbl[18] = V(0, 1, 1, 0, 0, E(1, 0, 0, 0, 0, 1));
        tbl[19] = V(0, 0, 0, 1, 0, E(1, 0, 0, 0, 0, 1));

        rst_n       = 1'b0;
        clk_1hz_en  = 1'b0;
        arm_btn     = 1'b0;
        off_btn     = 1'b0;
        snooze_btn  = 1'b0;
        alarm_match = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        chk("reset.alarm_enable",     16'(alarm_enable),     16'd0);
        chk("reset.ringing",          16'(ringing),          16'd0);
        chk("reset.buzzer",           16'(buzzer),           16'd0);
        chk("reset.snooze_active",    16'(snooze_active),    16'd0);
        chk("reset.snooze_remaining", 16'(snooze_remaining), 16'd0);
        chk("reset.state_dbg",        16'(state_dbg),        16'd0);
        @(negedge sys_clk);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            step(tbl[i].arm, tbl[i].off, tbl[i].snz, tbl[i].tick, tbl[i].match,
                 tbl[i].e, $sformatf("tbl%0d", i));
        end

`ifdef ALARM_CTRL_SNOOZE_EN
        // Manual snooze: full 60 s countdown then ring again.
        step(0, 0, 0, 0, 1, E(1, 1, 1, 0, 0, 2), "man_ring");
        step(0, 0, 1, 0, 1, E(1, 0, 0, 1, 60, 3), "man_snooze");
        for (int k = 1; k < 60; k++) begin
            step(0, 0, 0, 1, 0, E(1, 0, 0, 1, 60 - k, 3), "man_count");
        end
        step(0, 0, 0, 1, 0, E(1, 1, 1, 0, 0, 2), "man_expire");
        step(0, 1, 0, 0, 0, E(1, 0, 0, 0, 0, 1), "man_off");

        // Two auto-snoozes, then the third timeout acts as off with match high.
        step(0, 0, 0, 0, 1, E(1, 1, 1, 0, 0, 2), "auto_ring");
        for (int rep = 0; rep < 3; rep++) begin
            if (rep == 2) begin
                step(0, 0, 1, 0, 1, E(1, 1, 1, 0, 0, 2), "snz_exhausted");
            end
            four_ticks(1, $sformatf("auto%0d_tick", rep));
            if (rep < 2) begin
                step(0, 0, 0, 1, 1, E(1, 0, 0, 1, 60, 3), "auto_timeout");
                for (int k = 1; k <= 60; k++) begin
                    if (k < 60) step(0, 0, 0, 1, 1, E(1, 0, 0, 1, 60 - k, 3), "auto_count");
                    else        step(0, 0, 0, 1, 1, E(1, 1, 1, 0, 0, 2), "auto_expire");
                end
            end else begin
                step(0, 0, 0, 1, 1, E(1, 0, 0, 0, 0, 4), "auto_final");
            end
        end
        step(0, 0, 0, 0, 0, E(1, 0, 0, 0, 0, 1), "wait_clear");

        // Arm during SNOOZE disarms; then re-arm and snooze again for the reset check.
        step(0, 0, 0, 0, 1, E(1, 1, 1, 0, 0, 2), "s_ring");
        step(0, 0, 1, 0, 1, E(1, 0, 0, 1, 60, 3), "s_snooze");
        step(1, 0, 0, 1, 1, E(0, 0, 0, 0, 0, 0), "s_arm_disarm");
        step(1, 0, 0, 0, 0, E(1, 0, 0, 0, 0, 1), "s_rearm");
        step(0, 0, 0, 0, 1, E(1, 1, 1, 0, 0, 2), "r_ring");
        step(0, 0, 1, 0, 1, E(1, 0, 0, 1, 60, 3), "r_snooze");
        step(0, 0, 0, 1, 1, E(1, 0, 0, 1, 59, 3), "r_count");
`else
        // Snooze compiled out: button ignored, timeout behaves as off.
        step(0, 0, 0, 0, 1, E(1, 1, 1, 0, 0, 2), "u_ring");
        step(0, 0, 1, 0, 1, E(1, 1, 1, 0, 0, 2), "u_snz_ignored");
        four_ticks(1, "u_tick");
        step(0, 0, 0, 1, 1, E(1, 0, 0, 0, 0, 4), "u_timeout_match");
        step(0, 0, 0, 0, 0, E(1, 0, 0, 0, 0, 1), "u_clear");
        step(0, 0, 0, 0, 1, E(1, 1, 1, 0, 0, 2), "u_ring2");
        four_ticks(1, "u_tick2");
        step(0, 0, 0, 1, 0, E(1, 0, 0, 0, 0, 1), "u_timeout_nomatch");
        step(0, 0, 0, 0, 1, E(1, 1, 1, 0, 0, 2), "u_ring3");
        step(0, 0, 0, 1, 1, E(1, 1, 0, 0, 0, 2), "u_tick3");
`endif

        // Asynchronous reset in the middle of a cycle.
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.alarm_enable",     16'(alarm_enable),     16'd0);
        chk("arst.ringing",          16'(ringing),          16'd0);
        chk("arst.buzzer",           16'(buzzer),           16'd0);
        chk("arst.snooze_active",    16'(snooze_active),    16'd0);
        chk("arst.snooze_remaining", 16'(snooze_remaining), 16'd0);
        chk("arst.state_dbg",        16'(state_dbg),        16'd0);
        @(negedge sys_clk);
        alarm_match = 1'b0;
        @(negedge sys_clk);
        rst_n = 1'b1;
        // Must stay disarmed after reset until re-armed.
        step(0, 0, 0, 0, 1, E(0, 0, 0, 0, 0, 0), "post_rst_match");
        step(0, 0, 0, 0, 0, E(0, 0, 0, 0, 0, 0), "post_rst_idle");
        step(1, 0, 0, 0, 0, E(1, 0, 0, 0, 0, 1), "post_rst_arm");
        step(0, 0, 0, 0, 1, E(1, 1, 1, 0, 0, 2), "post_rst_ring");

        chk("scoreboard_drained", 16'(exp_q.size()), 16'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
